spart_rx_packer: RTL and testbench
==================================

Name: spart_rx_packer

Overview:
- Receive-side counterpart of the processor-to-SPART byte split path.
- Takes the byte stream from the SPART receiver and re-assembles it into 16-bit words, high byte first.
- Buffers the words in a small FIFO, which the processor pipeline drains with a read strobe.
- Sits between the SPART RX data/valid outputs and the register-file write source select.

Parameters:
- DEPTH, 4: number of 16-bit words buffered. Must be a power of two, at least 2.
- TIMEOUT_CYCLES, 1024: idle cycles tolerated between the high and low byte. Used only when the optional feature is compiled in.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- rx_valid  in  1  one-cycle strobe; rx_byte is valid this cycle.
- rx_byte  in  8  received byte.
- word_rd  in  1  pop the head word; honoured only when word_avail=1.
- word_data  out  16  head word (first-word fall-through); 16'h0000 when empty.
- word_avail  out  1  FIFO non-empty.
- count  out  $clog2(DEPTH)+1  words currently stored.
- half  out  1  high byte captured, low byte pending.
- overrun  out  1  sticky; a completed word was dropped because the FIFO was full.
- timeout_err  out  1  sticky; a partial word was discarded by timeout. Tied 0 without the optional feature.
- clr_err  in  1  clears overrun and timeout_err.

Behaviour:
- Reset values: phase=IDLE, pointers=0, count=0, word_avail=0, word_data=16'h0000, half=0, overrun=0, timeout_err=0, timeout counter=0. Storage array is not reset.
- Reset mid-word discards any captured high byte. Reset mid-FIFO discards all stored words.
- Phase FSM, IDLE:
  - rx_valid → latch rx_byte as hi_byte, go to HALF; half=1 from the next cycle.
- Phase FSM, HALF:
  - rx_valid → form word {hi_byte, rx_byte}, push it, return to IDLE.
- Push latency: the word is visible on word_data/word_avail the cycle after the low-byte strobe, provided the FIFO was empty.
- Full FIFO at push time:
  - Without a same-cycle pop: word dropped, overrun set, phase still returns to IDLE.
  - With word_rd in the same cycle: pop and push both succeed; count unchanged; no overrun.
- Pop: word_rd with word_avail=1 advances the read pointer; the next word appears the following cycle.
  - word_rd when empty is ignored; no pointer movement, no error.
- Pointers wrap modulo DEPTH. count spans 0..DEPTH inclusive.
- Simultaneous push and pop on a non-full, non-empty FIFO: count unchanged.
- Sticky flags: clr_err clears them next cycle. A set and a clear in the same cycle: set wins.
- No backpressure exists toward the SPART; bytes are never stalled, only dropped.

Optional Feature:
- Macro: SPART_RX_TIMEOUT_EN.
- Defined:
  - A counter runs while in HALF; it resets on entry to HALF and on any rx_valid.
  - After TIMEOUT_CYCLES consecutive HALF cycles without rx_valid: hi_byte is discarded, phase returns to IDLE, timeout_err is set.
  - An rx_valid arriving in the timeout cycle itself counts as a low byte: the word completes normally and no error is flagged.
- Undefined: HALF persists indefinitely, there is no counter logic, and timeout_err is constant 0.

Decomposition:
- Package spart_rx_pkg:
  - BYTE_W=8, WORD_W=16.
  - Phase enum {PH_IDLE, PH_HALF}.
  - EMPTY_WORD=16'h0000.
- One sub-module, spart_word_fifo:
  - Parameterised DEPTH synchronous FIFO.
  - Ports: push/pop/full/empty/count/head.
- spart_rx_packer itself holds the phase FSM, hi_byte register, sticky flags and the timeout counter.

Test Plan:
- Bytes 8'hAB then 8'hCD (any gap) → word_data=16'hABCD, word_avail=1, count=1 one cycle after the second strobe; half=1 only between the strobes.
- Five words pushed with DEPTH=4, no reads → count=4, fifth word dropped, overrun=1. Reads return words 1–4 in order; word_data=16'h0000 after the last pop.
- FIFO full; low byte strobe with word_rd in the same cycle → count stays 4, overrun=0, new word read out last.
- rst asserted after byte 8'h12 (half=1), then bytes 8'h34, 8'h56 → half=0 after reset; the single word read is 16'h3456.
- overrun=1; clr_err asserted in the same cycle as another dropped word → overrun stays 1. A lone clr_err the next cycle → overrun=0.
- With SPART_RX_TIMEOUT_EN and TIMEOUT_CYCLES=8:
  - Byte 8'h77 then silence for 8 cycles → half=0, timeout_err=1, count=0.
  - Repeat with the low byte arriving on cycle 8 → word 16'h77xx stored, timeout_err=0.

Source files
------------

// File: rtl/spart_rx_pkg.sv
// spart_rx_pkg
// Shared definitions for the SPART receive-side byte packer:
//   BYTE_W / WORD_W  - byte and packed word widths
//   phase_e          - packer phase (waiting for high byte / low byte)
//   EMPTY_WORD       - value presented on the word output when nothing is stored
//   is_pow2()        - elaboration helper for FIFO depth checking
package spart_rx_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    localparam logic [WORD_W-1:0] EMPTY_WORD = 16'h0000;

    typedef enum logic {
        PH_IDLE = 1'b0,
        PH_HALF = 1'b1
    } phase_e;

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/spart_rx_packer_if.sv
// spart_rx_packer_if
// Bundles the byte input, word output and status signals of spart_rx_packer.
//   rx_valid/rx_byte      - byte strobe from the SPART receiver
//   word_rd               - pop strobe from the processor
//   word_data/word_avail  - head word (fall-through) and non-empty flag
//   count                 - words stored, 0..DEPTH
//   half                  - high byte captured, low byte pending
//   overrun/timeout_err   - sticky error flags, cleared by clr_err
// Modports: master = processor/SPART side, slave = packer.
interface spart_rx_packer_if #(
    parameter int DEPTH = 4
) ();
    import spart_rx_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              rx_valid;
    logic [BYTE_W-1:0] rx_byte;
    logic              word_rd;
    logic [WORD_W-1:0] word_data;
    logic              word_avail;
    logic [CNT_W-1:0]  count;
    logic              half;
    logic              overrun;
    logic              timeout_err;
    logic              clr_err;

    modport master (
        output rx_valid, rx_byte, word_rd, clr_err,
        input  word_data, word_avail, count, half, overrun, timeout_err
    );

    modport slave (
        input  rx_valid, rx_byte, word_rd, clr_err,
        output word_data, word_avail, count, half, overrun, timeout_err
    );

endinterface

// File: rtl/spart_word_fifo.sv
// spart_word_fifo
// Synchronous first-word-fall-through FIFO of 16-bit words.
//   clk, rst    - clock, synchronous active-high reset (pointers/count only)
//   push, push_data - write request; accepted when not full, or when full
//                 and a pop happens in the same cycle
//   pop         - read request; ignored when empty
//   full, empty - occupancy flags
//   count       - words stored, 0..DEPTH
//   head        - word at the read pointer, EMPTY_WORD when empty
module spart_word_fifo
    import spart_rx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WORD_W-1:0]          push_data,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WORD_W-1:0]          head
);

    localparam int AW = $clog2(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_pop;
    logic              do_push;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? EMPTY_WORD : mem[rd_ptr];

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spart_rx_packer.sv
// spart_rx_packer
// Re-assembles the SPART receive byte stream into 16-bit words (high byte
// first) and buffers them in a DEPTH-word FIFO drained by word_rd.
//   clk, rst - system clock, synchronous active-high reset
//   bus      - spart_rx_packer_if.slave: rx_valid/rx_byte in, word_rd and
//              clr_err in, word_data/word_avail/count/half/overrun/
//              timeout_err out
// Optional build macro: SPART_RX_TIMEOUT_EN. When defined, a partial word
// left waiting TIMEOUT_CYCLES cycles for its low byte is discarded and
// timeout_err is set. When undefined, the high byte waits indefinitely and
// timeout_err is constant 0.
module spart_rx_packer
    import spart_rx_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst,
    spart_rx_packer_if.slave   bus
);

    if (!is_pow2(DEPTH) || DEPTH < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("spart_rx_packer: DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
    end

    phase_e            phase;
    logic [BYTE_W-1:0] hi_byte;
    logic              push_req;
    logic              fifo_full;
    logic              fifo_empty;
    logic              drop;
    logic              overrun_r;

    // The low byte strobe completes a word; there is no way to stall the
    // receiver, so the word is either stored or dropped.
    assign push_req = (phase == PH_HALF) && bus.rx_valid;
    assign drop     = push_req && fifo_full && !bus.word_rd;

    spart_word_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_req),
        .push_data ({hi_byte, bus.rx_byte}),
        .pop       (bus.word_rd),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (bus.count),
        .head      (bus.word_data)
    );

    // High byte is pure data; a stale value is harmless because phase gates it.
    always_ff @(posedge clk) begin
        if ((phase == PH_IDLE) && bus.rx_valid) begin
            hi_byte <= bus.rx_byte;
        end
    end

`ifdef SPART_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_cnt;
    logic          tmo_fire;
    logic          timeout_err_r;

    // Fires on the last tolerated idle HALF cycle; a low byte in that same
    // cycle takes priority and completes the word instead.
    assign tmo_fire = (phase == PH_HALF) && !bus.rx_valid &&
                      (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            phase   <= PH_IDLE;
            tmo_cnt <= '0;
        end else begin
            case (phase)
                PH_IDLE: begin
                    tmo_cnt <= '0;
                    if (bus.rx_valid) phase <= PH_HALF;
                end
                PH_HALF: begin
                    if (bus.rx_valid || tmo_fire) begin
                        phase   <= PH_IDLE;
                        tmo_cnt <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: begin
                    phase   <= PH_IDLE;
                    tmo_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_err_r <= 1'b0;
        end else begin
            timeout_err_r <= (timeout_err_r && !bus.clr_err) || tmo_fire;
        end
    end

    assign bus.timeout_err = timeout_err_r;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= PH_IDLE;
        end else begin
            case (phase)
                PH_IDLE: if (bus.rx_valid) phase <= PH_HALF;
                PH_HALF: if (bus.rx_valid) phase <= PH_IDLE;
                default: phase <= PH_IDLE;
            endcase
        end
    end

    assign bus.timeout_err = 1'b0;
`endif

    // Sticky: a new drop in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= (overrun_r && !bus.clr_err) || drop;
        end
    end

    assign bus.overrun    = overrun_r;
    assign bus.half       = (phase == PH_HALF);
    assign bus.word_avail = !fifo_empty;

endmodule

// File: tb/tb_spart_rx_packer.sv
// tb_spart_rx_packer
// Directed bench for spart_rx_packer (DEPTH=4, TIMEOUT_CYCLES=8). Expected
// words are queued by the stimulus; a monitor compares each popped head word.
module tb_spart_rx_packer;

    localparam int DEPTH = 4;
    localparam int TMO   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    spart_rx_packer_if #(.DEPTH(DEPTH)) bus ();

    spart_rx_packer #(
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted pop must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && bus.word_rd && bus.word_avail) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pop_unexpected: got %0h expected none", bus.word_data);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (bus.word_data !== e) begin
                    n_fail++;
                    $display("FAIL pop_word: got %0h expected %0h", bus.word_data, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_byte  = b;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w, input bit expect_stored);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
        if (expect_stored) exp_q.push_back(w);
    endtask

    task automatic pop_one();
        bus.word_rd = 1'b1;
        tick();
        bus.word_rd = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_byte  = 8'h00;
        bus.word_rd  = 1'b0;
        bus.clr_err  = 1'b0;
        rst = 1'b1;
        idle(3);
        check("rst_count", 32'(bus.count), 0);
        check("rst_avail", 32'(bus.word_avail), 0);
        check("rst_data", 32'(bus.word_data), 0);
        check("rst_half", 32'(bus.half), 0);
        check("rst_overrun", 32'(bus.overrun), 0);
        check("rst_timeout", 32'(bus.timeout_err), 0);
        rst = 1'b0;
        tick();

        // Basic pack with a gap between bytes
        send_byte(8'hAB);
        check("half_after_hi", 32'(bus.half), 1);
        idle(2);
        check("half_gap", 32'(bus.half), 1);
        check("avail_gap", 32'(bus.word_avail), 0);
        send_byte(8'hCD);
        exp_q.push_back(16'hABCD);
        check("pack_data", 32'(bus.word_data), 32'h0000ABCD);
        check("pack_avail", 32'(bus.word_avail), 1);
        check("pack_count", 32'(bus.count), 1);
        check("pack_half", 32'(bus.half), 0);
        pop_one();
        check("pop_empty_data", 32'(bus.word_data), 0);
        check("pop_empty_count", 32'(bus.count), 0);
        pop_one();  // pop on empty is ignored
        check("pop_ignored_count", 32'(bus.count), 0);

        // Overflow: fifth word dropped
        send_word(16'h1111, 1);
        send_word(16'h2222, 1);
        send_word(16'h3333, 1);
        send_word(16'h4444, 1);
        check("full_overrun0", 32'(bus.overrun), 0);
        send_word(16'h5555, 0);
        check("ovf_count", 32'(bus.count), 4);
        check("ovf_overrun", 32'(bus.overrun), 1);
        check("ovf_half", 32'(bus.half), 0);
        for (int i = 0; i < 4; i++) pop_one();
        check("ovf_drain_data", 32'(bus.word_data), 0);
        check("ovf_drain_avail", 32'(bus.word_avail), 0);
        check("ovf_sticky", 32'(bus.overrun), 1);
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        check("ovf_cleared", 32'(bus.overrun), 0);

        // Full FIFO with push and pop in the same cycle
        send_word(16'hA001, 1);
        send_word(16'hA002, 1);
        send_word(16'hA003, 1);
        send_word(16'hA004, 1);
        send_byte(8'hB0);
        bus.rx_valid = 1'b1;
        bus.rx_byte  = 8'h0B;
        bus.word_rd  = 1'b1;
        exp_q.push_back(16'hB00B);
        tick();
        bus.rx_valid = 1'b0;
        bus.word_rd  = 1'b0;
        check("pp_count", 32'(bus.count), 4);
        check("pp_overrun", 32'(bus.overrun), 0);
        for (int i = 0; i < 4; i++) pop_one();
        check("pp_drained", 32'(bus.count), 0);

        // Reset mid-FIFO and mid-word
        send_word(16'h9999, 0);
        send_byte(8'h12);
        check("mid_half", 32'(bus.half), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_half", 32'(bus.half), 0);
        check("mid_rst_count", 32'(bus.count), 0);
        check("mid_rst_avail", 32'(bus.word_avail), 0);
        send_word(16'h3456, 1);
        check("mid_word", 32'(bus.word_data), 32'h00003456);
        check("mid_count", 32'(bus.count), 1);
        pop_one();

        // Set beats clear in the same cycle
        send_word(16'hC001, 1);
        send_word(16'hC002, 1);
        send_word(16'hC003, 1);
        send_word(16'hC004, 1);
        send_word(16'hD00D, 0);
        check("sc_overrun_set", 32'(bus.overrun), 1);
        send_byte(8'hE0);
        bus.rx_valid = 1'b1;
        bus.rx_byte  = 8'h0E;
        bus.clr_err  = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
        bus.clr_err  = 1'b0;
        check("sc_set_wins", 32'(bus.overrun), 1);
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        check("sc_lone_clear", 32'(bus.overrun), 0);
        for (int i = 0; i < 4; i++) pop_one();
        check("sc_drained", 32'(bus.count), 0);

`ifdef SPART_RX_TIMEOUT_EN
        send_byte(8'h77);
        idle(TMO - 1);
        check("tmo_pending_half", 32'(bus.half), 1);
        check("tmo_pending_err", 32'(bus.timeout_err), 0);
        idle(1);
        check("tmo_half", 32'(bus.half), 0);
        check("tmo_err", 32'(bus.timeout_err), 1);
        check("tmo_count", 32'(bus.count), 0);
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        check("tmo_cleared", 32'(bus.timeout_err), 0);
        send_byte(8'h77);
        idle(TMO - 1);
        send_byte(8'h88);
        exp_q.push_back(16'h7788);
        check("tmo_edge_err", 32'(bus.timeout_err), 0);
        check("tmo_edge_count", 32'(bus.count), 1);
        check("tmo_edge_half", 32'(bus.half), 0);
        pop_one();
`else
        send_byte(8'h77);
        idle(3 * TMO);
        check("notmo_half", 32'(bus.half), 1);
        check("notmo_err", 32'(bus.timeout_err), 0);
        send_byte(8'h88);
        exp_q.push_back(16'h7788);
        check("notmo_count", 32'(bus.count), 1);
        pop_one();
`endif

        idle(2);
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
